// File: rtl/ca_ingr_rcv_monitor_pkg.sv
// Shared definitions for the ingress receive protocol monitor.
// - Bit positions of the fields inside the 64-bit req/resp tdata word.
// - Bit positions of each error inside the 16-bit protocol_error vector.
// - The pending-request entry held in the in-order request queue.
package ca_ingr_rcv_monitor_pkg;

  // tdata field layout shared by req and resp
  localparam int BL_MSB  = 63;
  localparam int BL_LSB  = 48;
  localparam int CH_MSB  = 47;
  localparam int CH_LSB  = 40;
  localparam int SOF_BIT = 33;
  localparam int EOF_BIT = 32;

  localparam int BL_W   = BL_MSB - BL_LSB + 1;
  localparam int PEND_W = 20;

  // protocol_error bit layout (bits 4, 5, 11, 14, 15 are reserved 0)
  localparam int ERR_RESP_CH        = 0;
  localparam int ERR_RESP_LEN_GT    = 1;
  localparam int ERR_RESP_SOF       = 2;
  localparam int ERR_RESP_EOF       = 3;
  localparam int ERR_REQ_FULL       = 6;
  localparam int ERR_RESP_EMPTY     = 7;
  localparam int ERR_REQ_LEN_MAX    = 8;
  localparam int ERR_DATA_NO_CREDIT = 9;
  localparam int ERR_DATA_OVF       = 10;
  localparam int ERR_REQ_LEN_ZERO   = 12;
  localparam int ERR_RESP_LEN_EQ    = 13;

  // Channel is kept at full field width; users take the low CH_W bits.
  typedef struct packed {
    logic [CH_MSB-CH_LSB:0] ch;
    logic [BL_W-1:0]        len;
    logic                   sof;
    logic                   eof;
  } pend_entry_t;

endpackage

// File: rtl/ca_ingr_rcv_monitor_req_queue.sv
// In-order pending-request queue for the ingress receive monitor.
// Holds REQ_DEPTH entries, tracks how many beats of the head request have
// already been answered by partial responses, and counts outstanding
// requests per channel.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_push, i_push_*             enqueue one request (caller guarantees room)
//   i_pop                        retire the head request
//   i_adv, i_adv_len             partial response: head consumed by i_adv_len
//   o_empty, o_full              queue occupancy flags
//   o_ch_full                    channel i_push_ch is at MAX_OUTSTANDING
//   o_head_*                     head entry fields
//   o_head_used                  beats of the head already answered
module ca_ingr_rcv_monitor_req_queue
  import ca_ingr_rcv_monitor_pkg::*;
#(
  parameter int NUM_CH          = 16,
  parameter int REQ_DEPTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic [CH_W-1:0] i_push_ch,
  input  logic [BL_W-1:0] i_push_len,
  input  logic            i_push_sof,
  input  logic            i_push_eof,
  input  logic            i_pop,
  input  logic            i_adv,
  input  logic [BL_W-1:0] i_adv_len,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_ch_full,
  output logic [CH_W-1:0] o_head_ch,
  output logic [BL_W-1:0] o_head_len,
  output logic [BL_W-1:0] o_head_used,
  output logic            o_head_sof,
  output logic            o_head_eof
);

  localparam int AW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  pend_entry_t     r_mem [REQ_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [BL_W-1:0] r_head_used;
  logic [CW-1:0]   r_ch_cnt [NUM_CH];

  pend_entry_t w_push_entry;
  pend_entry_t w_head;

  always_comb begin
    w_push_entry     = '0;
    w_push_entry.ch  = (CH_MSB-CH_LSB+1)'(i_push_ch);
    w_push_entry.len = i_push_len;
    w_push_entry.sof = i_push_sof;
    w_push_entry.eof = i_push_eof;
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == (AW+1)'(REQ_DEPTH));
  assign o_ch_full   = (r_ch_cnt[i_push_ch] == CW'(MAX_OUTSTANDING));
  assign o_head_ch   = w_head.ch[CH_W-1:0];
  assign o_head_len  = w_head.len;
  assign o_head_used = r_head_used;
  assign o_head_sof  = w_head.sof;
  assign o_head_eof  = w_head.eof;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_head_used <= '0;
      for (int i = 0; i < NUM_CH; i++) r_ch_cnt[i] <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A new head always starts with nothing answered.
      if (i_pop)      r_head_used <= '0;
      else if (i_adv) r_head_used <= r_head_used + i_adv_len;

      // Push and pop on the same channel cancel out.
      for (int i = 0; i < NUM_CH; i++) begin
        if ((i_push && i_push_ch == CH_W'(i)) && !(i_pop && o_head_ch == CH_W'(i)))
          r_ch_cnt[i] <= r_ch_cnt[i] + 1'b1;
        else if (!(i_push && i_push_ch == CH_W'(i)) && (i_pop && o_head_ch == CH_W'(i)))
          r_ch_cnt[i] <= r_ch_cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ca_ingr_rcv_monitor_protocol_mc.sv
// Multi-channel passive protocol monitor for the ingress receive path.
// Watches the req, resp and data handshakes and reports a registered 16-bit
// error vector one cycle after the offending transfer.
// Handshake semantics: a transfer happens on a cycle where tvalid and tready
// are both high; the monitor only observes and never drives ready.
// Ports:
//   ap_clk, ap_rst                  clock, synchronous active-high reset
//   req_*/resp_*/data_*             observed handshakes
//   protocol_error, _ap_vld         registered error vector and non-zero flag
//   err_clear                       clears sticky/first-error capture
//   protocol_error_sticky           OR of errors since reset/clear
//   first_error                     first non-zero error vector
// Optional feature macro: CA_INGR_RCV_MONITOR_PROTOCOL_STICKY_EN enables the
// sticky and first-error capture; otherwise those outputs are 0.
module ca_ingr_rcv_monitor_protocol_mc
  import ca_ingr_rcv_monitor_pkg::*;
#(
  parameter int DATA_W          = 512,
  parameter int NUM_CH          = 16,
  parameter int REQ_DEPTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_BURST       = 256,
  parameter int STRICT_LEN      = 0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              req_tready,
  input  logic              req_tvalid,
  input  logic [63:0]       req_tdata,
  input  logic              resp_tready,
  input  logic              resp_tvalid,
  input  logic [63:0]       resp_tdata,
  input  logic              data_tready,
  input  logic              data_tvalid,
  input  logic [DATA_W-1:0] data_tdata,
  output logic [15:0]       protocol_error,
  output logic              protocol_error_ap_vld,
  input  logic              err_clear,
  output logic [15:0]       protocol_error_sticky,
  output logic [15:0]       first_error
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              w_req_fire, w_resp_fire, w_data_fire;
  logic [BL_W-1:0]   w_req_len, w_resp_len;
  logic [CH_W-1:0]   w_req_ch, w_resp_ch;
  logic              w_q_empty, w_q_full, w_q_ch_full;
  logic [CH_W-1:0]   w_head_ch;
  logic [BL_W-1:0]   w_head_len, w_head_used, w_head_rem;
  logic              w_head_sof, w_head_eof;
  logic              w_push, w_resp_take, w_resp_final, w_pop, w_adv;
  logic              w_data_ok;
  logic [PEND_W-1:0] w_pend_add;
  logic [PEND_W:0]   w_pend_sum;
  logic [15:0]       w_err;
  logic              w_unused;

  logic [PEND_W-1:0] r_pend;
  logic [15:0]       r_err;
  logic              r_vld;

  assign w_req_fire  = req_tvalid & req_tready;
  assign w_resp_fire = resp_tvalid & resp_tready;
  assign w_data_fire = data_tvalid & data_tready;

  assign w_req_len  = req_tdata[BL_MSB:BL_LSB];
  assign w_resp_len = resp_tdata[BL_MSB:BL_LSB];
  assign w_req_ch   = req_tdata[CH_LSB +: CH_W];
  assign w_resp_ch  = resp_tdata[CH_LSB +: CH_W];

  // Zero-length reqs are never queued; full queue or channel drops the req.
  assign w_push = w_req_fire && (w_req_len != '0) && !w_q_full && !w_q_ch_full;

  // Zero-length resps are ignored; resps see the queue as of cycle start.
  assign w_resp_take  = w_resp_fire && (w_resp_len != '0) && !w_q_empty;
  assign w_head_rem   = w_head_len - w_head_used;
  assign w_resp_final = (w_resp_len >= w_head_rem);
  assign w_pop        = w_resp_take && w_resp_final;
  assign w_adv        = w_resp_take && !w_resp_final;

  // Data checks against credit held at cycle start; new resp credit is
  // usable only from the following cycle.
  assign w_data_ok  = w_data_fire && (r_pend != '0);
  assign w_pend_add = w_resp_take ? PEND_W'(w_resp_len) : '0;
  assign w_pend_sum = {1'b0, r_pend} + {1'b0, w_pend_add};

  always_comb begin
    w_err = '0;
    if (w_req_fire) begin
      if (w_req_len == '0) begin
        w_err[ERR_REQ_LEN_ZERO] = 1'b1;
      end else begin
        if (32'(w_req_len) > MAX_BURST) w_err[ERR_REQ_LEN_MAX] = 1'b1;
        if (w_q_full || w_q_ch_full)    w_err[ERR_REQ_FULL]    = 1'b1;
      end
    end
    if (w_resp_fire && (w_resp_len != '0) && w_q_empty) w_err[ERR_RESP_EMPTY] = 1'b1;
    if (w_resp_take) begin
      if (w_resp_ch != w_head_ch)                        w_err[ERR_RESP_CH]      = 1'b1;
      if (w_resp_len > w_head_rem)                       w_err[ERR_RESP_LEN_GT]  = 1'b1;
      if (w_head_used == '0 && resp_tdata[SOF_BIT] != w_head_sof)
                                                         w_err[ERR_RESP_SOF]     = 1'b1;
      if (w_resp_final && resp_tdata[EOF_BIT] != w_head_eof)
                                                         w_err[ERR_RESP_EOF]     = 1'b1;
      if (STRICT_LEN != 0 && w_resp_len != w_head_rem)   w_err[ERR_RESP_LEN_EQ]  = 1'b1;
    end
    if (w_data_fire && (r_pend == '0)) w_err[ERR_DATA_NO_CREDIT] = 1'b1;
    if (w_pend_sum[PEND_W])            w_err[ERR_DATA_OVF]       = 1'b1;
  end

  ca_ingr_rcv_monitor_req_queue #(
    .NUM_CH          (NUM_CH),
    .REQ_DEPTH       (REQ_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CH_W            (CH_W)
  ) u_req_queue (
    .i_clk       (ap_clk),
    .i_rst       (ap_rst),
    .i_push      (w_push),
    .i_push_ch   (w_req_ch),
    .i_push_len  (w_req_len),
    .i_push_sof  (req_tdata[SOF_BIT]),
    .i_push_eof  (req_tdata[EOF_BIT]),
    .i_pop       (w_pop),
    .i_adv       (w_adv),
    .i_adv_len   (w_resp_len),
    .o_empty     (w_q_empty),
    .o_full      (w_q_full),
    .o_ch_full   (w_q_ch_full),
    .o_head_ch   (w_head_ch),
    .o_head_len  (w_head_len),
    .o_head_used (w_head_used),
    .o_head_sof  (w_head_sof),
    .o_head_eof  (w_head_eof)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_pend <= '0;
      r_err  <= '0;
      r_vld  <= 1'b0;
    end else begin
      // Saturate on overflow, then spend one beat of credit if data moved.
      if (w_pend_sum[PEND_W]) r_pend <= {PEND_W{1'b1}} - PEND_W'(w_data_ok);
      else                    r_pend <= w_pend_sum[PEND_W-1:0] - PEND_W'(w_data_ok);
      r_err <= w_err;
      r_vld <= |w_err;
    end
  end

  assign protocol_error        = r_err;
  assign protocol_error_ap_vld = r_vld;

`ifdef CA_INGR_RCV_MONITOR_PROTOCOL_STICKY_EN
  logic [15:0] r_sticky;
  logic [15:0] r_first;

  // Clear wins over a same-cycle error; that error is lost unless it recurs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || err_clear) begin
      r_sticky <= '0;
      r_first  <= '0;
    end else begin
      r_sticky <= r_sticky | w_err;
      if (r_first == '0) r_first <= w_err;
    end
  end

  assign protocol_error_sticky = r_sticky;
  assign first_error           = r_first;
`else
  assign protocol_error_sticky = '0;
  assign first_error           = '0;
`endif

  // Payload bits outside the decoded fields are intentionally not inspected.
  assign w_unused = ^{req_tdata, resp_tdata, data_tdata, err_clear};

endmodule

// File: tb/tb_ca_ingr_rcv_monitor_protocol_mc.sv
module tb_ca_ingr_rcv_monitor_protocol_mc;

  localparam int DATA_W    = 512;
  localparam int NUM_CH    = 16;
  localparam int REQ_DEPTH = 16;
  localparam int MAX_OUT   = 4;
  localparam int MAX_BURST = 256;
  localparam int PEND_MAX  = (1 << 20) - 1;

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic              req_tready = 0, req_tvalid = 0;
  logic [63:0]       req_tdata = '0;
  logic              resp_tready = 0, resp_tvalid = 0;
  logic [63:0]       resp_tdata = '0;
  logic              data_tready = 0, data_tvalid = 0;
  logic [DATA_W-1:0] data_tdata = '0;
  logic              err_clear = 0;
  logic [15:0]       protocol_error, sticky, first_err;
  logic              ap_vld;
  logic [15:0]       protocol_error_s, sticky_s, first_err_s;
  logic              ap_vld_s;

  ca_ingr_rcv_monitor_protocol_mc #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .REQ_DEPTH(REQ_DEPTH),
    .MAX_OUTSTANDING(MAX_OUT), .MAX_BURST(MAX_BURST), .STRICT_LEN(0)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_tready(req_tready), .req_tvalid(req_tvalid), .req_tdata(req_tdata),
    .resp_tready(resp_tready), .resp_tvalid(resp_tvalid), .resp_tdata(resp_tdata),
    .data_tready(data_tready), .data_tvalid(data_tvalid), .data_tdata(data_tdata),
    .protocol_error(protocol_error), .protocol_error_ap_vld(ap_vld),
    .err_clear(err_clear), .protocol_error_sticky(sticky), .first_error(first_err)
  );

  ca_ingr_rcv_monitor_protocol_mc #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .REQ_DEPTH(REQ_DEPTH),
    .MAX_OUTSTANDING(MAX_OUT), .MAX_BURST(MAX_BURST), .STRICT_LEN(1)
  ) dut_strict (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_tready(req_tready), .req_tvalid(req_tvalid), .req_tdata(req_tdata),
    .resp_tready(resp_tready), .resp_tvalid(resp_tvalid), .resp_tdata(resp_tdata),
    .data_tready(data_tready), .data_tvalid(data_tvalid), .data_tdata(data_tdata),
    .protocol_error(protocol_error_s), .protocol_error_ap_vld(ap_vld_s),
    .err_clear(err_clear), .protocol_error_sticky(sticky_s), .first_error(first_err_s)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int ch;
    int len;
    int rem;
    bit started;
    bit sof;
    bit eof;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_cnt[NUM_CH];
  int          m_pend;
  logic [15:0] m_sticky, m_first;
  logic [15:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [63:0] mk(input int ch, input int len, input bit sof, input bit eof);
    logic [63:0] d;
    d = '0;
    d[63:48] = 16'(len);
    d[47:40] = 8'(ch);
    d[33]    = sof;
    d[32]    = eof;
    return d;
  endfunction

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    m_pend   = 0;
    m_sticky = '0;
    m_first  = '0;
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock of stimulus + model + checks --------
  task automatic step(input logic rqv, input logic rqr, input logic [63:0] rqd,
                      input logic rsv, input logic rsr, input logic [63:0] rsd,
                      input logic dv, input logic dr, input logic clr);
    logic [15:0] e, es;
    int rq_ch, rq_len, rs_ch, rs_len, add, dec;
    bit do_push, do_pop, strict_bad;
    m_ent_t h, n;
    req_tvalid = rqv;  req_tready = rqr;  req_tdata = rqd;
    resp_tvalid = rsv; resp_tready = rsr; resp_tdata = rsd;
    data_tvalid = dv;  data_tready = dr;
    data_tdata = {16{$urandom}};
    err_clear = clr;

    e = '0; do_push = 0; do_pop = 0; strict_bad = 0; add = 0; dec = 0;
    rq_len = int'(rqd[63:48]); rq_ch = int'(rqd[47:40]) % NUM_CH;
    rs_len = int'(rsd[63:48]); rs_ch = int'(rsd[47:40]) % NUM_CH;

    if (rqv && rqr) begin
      if (rq_len == 0) e[12] = 1'b1;
      else begin
        if (rq_len > MAX_BURST) e[8] = 1'b1;
        if (mq.size() >= REQ_DEPTH || m_cnt[rq_ch] >= MAX_OUT) e[6] = 1'b1;
        else do_push = 1;
      end
    end
    if (rsv && rsr && rs_len != 0) begin
      if (mq.size() == 0) e[7] = 1'b1;
      else begin
        h = mq[0];
        if (h.ch != rs_ch) e[0] = 1'b1;
        if (rs_len > h.rem) e[1] = 1'b1;
        if (!h.started && rsd[33] != h.sof) e[2] = 1'b1;
        if (rs_len >= h.rem && rsd[32] != h.eof) e[3] = 1'b1;
        if (rs_len != h.rem) strict_bad = 1;
        if (rs_len >= h.rem) do_pop = 1;
        else begin
          h.rem -= rs_len;
          h.started = 1;
          mq[0] = h;
        end
        add = rs_len;
      end
    end
    if (dv && dr) begin
      if (m_pend == 0) e[9] = 1'b1;
      else dec = 1;
    end
    if (m_pend + add > PEND_MAX) begin
      e[10] = 1'b1;
      m_pend = PEND_MAX;
    end else m_pend += add;
    m_pend -= dec;
    if (do_pop) begin
      m_cnt[mq[0].ch]--;
      void'(mq.pop_front());
    end
    if (do_push) begin
      n.ch = rq_ch; n.len = rq_len; n.rem = rq_len; n.started = 0;
      n.sof = rqd[33]; n.eof = rqd[32];
      mq.push_back(n);
      m_cnt[rq_ch]++;
    end
    es = e;
    if (strict_bad) es[13] = 1'b1;
    if (clr) begin
      m_sticky = '0;
      m_first  = '0;
    end else begin
      m_sticky |= e;
      if (m_first == '0) m_first = e;
    end
    exp_q.push_back(e);
    exp_q.push_back(es);

    @(posedge ap_clk);
    #1;
    check16("err", protocol_error, exp_q.pop_front());
    check16("vld", {15'd0, ap_vld}, {15'd0, |e});
    check16("err_strict", protocol_error_s, exp_q.pop_front());
    check16("vld_strict", {15'd0, ap_vld_s}, {15'd0, |es});
`ifdef CA_INGR_RCV_MONITOR_PROTOCOL_STICKY_EN
    check16("sticky", sticky, m_sticky);
    check16("first", first_err, m_first);
`else
    check16("sticky", sticky, 16'h0);
    check16("first", first_err, 16'h0);
`endif
  endtask

  task automatic t_idle();                  step(0,0,'0, 0,0,'0, 0,0, 0); endtask
  task automatic t_req(input logic [63:0] d);  step(1,1,d, 0,0,'0, 0,0, 0); endtask
  task automatic t_resp(input logic [63:0] d); step(0,0,'0, 1,1,d, 0,0, 0); endtask
  task automatic t_data();                  step(0,0,'0, 0,0,'0, 1,1, 0); endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    req_tvalid = 0; resp_tvalid = 0; data_tvalid = 0; err_clear = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    model_reset();
    check16("rst_err", protocol_error, 16'h0);
    check16("rst_vld", {15'd0, ap_vld}, 16'h0);
    check16("rst_sticky", sticky, 16'h0);
    check16("rst_first", first_err, 16'h0);
    ap_rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] rqd, rsd;
    int len, rem;
    model_reset();
    do_reset();

    // clean single transfer
    t_req(mk(3, 8, 1, 1));
    check16("clean_req", protocol_error, 16'h0);
    t_resp(mk(3, 8, 1, 1));
    check16("clean_resp", protocol_error, 16'h0);
    for (int i = 0; i < 8; i++) t_data();
    check16("clean_data", {15'd0, ap_vld}, 16'h0);

    // partial responses
    do_reset();
    t_req(mk(2, 8, 1, 1));
    t_resp(mk(2, 4, 1, 0));
    check16("partial1", protocol_error, 16'h0);
    check16("partial1_strict", protocol_error_s, 16'h2000);
    t_resp(mk(2, 4, 0, 1));
    check16("partial2", protocol_error, 16'h0);
    check16("partial2_strict", protocol_error_s, 16'h0);
    t_resp(mk(2, 1, 1, 1));
    check16("partial_popped", protocol_error, 16'h0080);

    // resp on empty queue, alone and with same-cycle req
    do_reset();
    t_resp(mk(1, 4, 1, 1));
    check16("empty_resp", protocol_error, 16'h0080);
    check16("empty_vld", {15'd0, ap_vld}, 16'h1);
    step(1,1,mk(1, 4, 1, 1), 1,1,mk(1, 4, 1, 1), 0,0, 0);
    check16("same_cycle_req", protocol_error, 16'h0080);
    t_resp(mk(1, 4, 1, 1));
    check16("next_cycle_visible", protocol_error, 16'h0);

    // per-channel limit, zero length, over-long burst
    do_reset();
    for (int i = 0; i < 4; i++) t_req(mk(0, 1, 1, 1));
    t_req(mk(0, 1, 1, 1));
    check16("ch_full", protocol_error, 16'h0040);
    t_req(mk(4, 0, 1, 1));
    check16("len_zero", protocol_error, 16'h1000);
    t_req(mk(7, 300, 1, 1));
    check16("len_max", protocol_error, 16'h0100);

    // channel mismatch then data underrun
    do_reset();
    t_req(mk(5, 4, 1, 1));
    t_resp(mk(6, 4, 1, 1));
    check16("ch_mismatch", protocol_error, 16'h0001);
    for (int i = 0; i < 4; i++) t_data();
    t_data();
    check16("data_underrun", protocol_error, 16'h0200);

    // sticky / first-error capture and clear
    do_reset();
    t_resp(mk(1, 4, 1, 1));
    t_req(mk(5, 4, 1, 1));
    t_resp(mk(6, 4, 1, 1));
    t_idle();
`ifdef CA_INGR_RCV_MONITOR_PROTOCOL_STICKY_EN
    check16("first_capture", first_err, 16'h0080);
    check16("sticky_or", sticky, 16'h0081);
`else
    check16("first_tied", first_err, 16'h0000);
    check16("sticky_tied", sticky, 16'h0000);
`endif
    step(0,0,'0, 1,1,mk(1, 4, 1, 1), 0,0, 1);
    check16("clear_first", first_err, 16'h0);
    check16("clear_sticky", sticky, 16'h0);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      case ($urandom_range(0, 19))
        0:       len = 0;
        1:       len = 300;
        default: len = $urandom_range(1, 12);
      endcase
      rqd = mk($urandom_range(0, 255), len, 1'($urandom), 1'($urandom));
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        rem = mq[0].rem;
        case ($urandom_range(0, 9))
          0:       len = rem + 1;
          1:       len = 0;
          2, 3:    len = rem;
          default: len = $urandom_range(1, rem);
        endcase
        rsd = mk(mq[0].ch + NUM_CH * $urandom_range(0, 1), len,
                 ($urandom_range(0, 7) == 0) ? ~mq[0].sof : mq[0].sof,
                 ($urandom_range(0, 7) == 0) ? ~mq[0].eof : mq[0].eof);
      end else begin
        rsd = mk($urandom_range(0, 255), $urandom_range(0, 12), 1'($urandom), 1'($urandom));
      end
      step(1'($urandom), ($urandom_range(0, 3) != 0), rqd,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), rsd,
           1'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ca_ingr_rcv_monitor_protocol_mc.md
Name: ca_ingr_rcv_monitor_protocol_mc

Overview:
Parametrised multi-channel protocol monitor for the ingress receive path. It passively observes the req, resp and data AXI4-Stream-style handshakes and checks them against the ingress protocol. Unlike the previous monitor, it is pure RTL with no HLS core, has per-channel outstanding tracking and supports partial responses. It reports a 16-bit per-cycle error vector in the existing protocol_error bit layout and sits beside the receive adaptor, feeding the error-collection register block.

Parameters:
- DATA_W, 512, data_tdata width (monitored for handshake only).
- NUM_CH, 16, number of channels; channel id = req/resp tdata[47:40] truncated to CH_W = clog2(NUM_CH).
- REQ_DEPTH, 16, depth of the in-order pending-request queue (power of 2).
- MAX_OUTSTANDING, 4, maximum pending reqs per channel.
- MAX_BURST, 256, maximum legal req burst_length in beats.
- STRICT_LEN, 0, 1 = resp burst_length must equal the head req; 0 = partial resps allowed.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- req_tready / req_tvalid  in  1  req handshake
- req_tdata  in  64  [63:48] burst_length, [47:40] channel, [33] sof, [32] eof
- resp_tready / resp_tvalid  in  1  resp handshake
- resp_tdata  in  64  same layout as req
- data_tready / data_tvalid  in  1  data handshake
- data_tdata  in  DATA_W  unused except lint
- protocol_error  out  16  registered error vector
- protocol_error_ap_vld  out  1  high when the registered vector is non-zero
- err_clear  in  1  clears sticky state (used only with optional feature)
- protocol_error_sticky  out  16  OR of all errors since reset or clear (optional feature, else 0)
- first_error  out  16  vector of the first erroneous cycle (optional feature, else 0)

Behaviour:
- Handshake fire = tvalid & tready. Monitor never drives ready.
- Req fire:
  - burst_length==0 -> bit12. The req is not queued.
  - burst_length>MAX_BURST -> bit8. The req is still queued.
  - Queue full, or channel count==MAX_OUTSTANDING -> bit6. The req is dropped.
  - Otherwise push {ch, len, sof, eof} and increment ch_cnt[ch].
- Resp fire with burst_length==0: ignored entirely, no errors.
- Resp fire with a non-empty queue: compare against the head entry.
  - ch mismatch -> bit0.
  - len > head remaining -> bit1.
  - sof != head.sof, only on the first resp for that head -> bit2.
  - eof != head.eof, only on the final resp -> bit3.
  - STRICT_LEN=1 and len != head remaining -> bit13.
  - If len >= remaining, pop the head and decrement ch_cnt; else remaining -= len.
  - Add len to data_beats_pending.
- Resp fire with an empty queue -> bit7.
- Visibility: a req pushed in cycle N is visible to resp from N+1. A same-cycle req+resp on an empty queue flags bit7.
- Data fire with data_beats_pending==0 -> bit9; otherwise decrement. Resp credit is usable from the next cycle.
- data_beats_pending is 20 bits. An add that would overflow saturates and sets bit10.
- Bits 4, 5, 11, 14, 15 are reserved 0.
- Latency: protocol_error and ap_vld are registered, one cycle after the fire.
- Simultaneous push+pop keeps occupancy unchanged. ch_cnt for the same channel is +1-1 = unchanged.
- Reset: queue, counters, remaining, protocol_error, ap_vld, sticky and first_error all go to 0. Reset mid-burst discards all state with no error.

Optional Feature:
- Macro CA_INGR_RCV_MONITOR_PROTOCOL_STICKY_EN.
- Defined:
  - protocol_error_sticky |= each cycle's vector.
  - first_error captures the first non-zero vector and holds until err_clear.
  - err_clear has priority over a same-cycle error: clear wins, and that error is captured next cycle only if it recurs.
- Undefined: both outputs are tied to 0 and err_clear is ignored.

Decomposition:
- Package ca_ingr_rcv_monitor_pkg:
  - field offsets (BL_MSB/LSB, CH_MSB/LSB, SOF_BIT, EOF_BIT);
  - error bit index constants ERR_RESP_CH=0 … ERR_RESP_LEN_EQ=13;
  - pending-entry struct typedef.
- One sub-module: ca_ingr_rcv_monitor_req_queue, the REQ_DEPTH FIFO with head-remaining register and per-channel counters.

Test Plan:
- Req ch3 len8 sof1 eof1, then resp ch3 len8 sof1 eof1, then 8 data beats -> protocol_error stays 0 and ap_vld stays 0.
- Req ch2 len8, then resp ch2 len4 followed by resp ch2 len4 eof1, STRICT_LEN=0 -> no error. The head pops on the second resp. With STRICT_LEN=1, bit13 fires one cycle after the first resp.
- Resp ch1 len4 with an empty queue -> protocol_error=16'h0080 and ap_vld=1 next cycle. Same result when a req fires in the same cycle.
- Five reqs on ch0 with MAX_OUTSTANDING=4 -> the fifth gives 16'h0040. A req with len0 -> 16'h1000. A req with len300 -> 16'h0100.
- Req ch5 len4, then resp ch6 len4, then 5 data beats -> 16'h0001 after the resp and 16'h0200 on the fifth beat.
- With the sticky macro: errors 0x0080 then 0x0001 -> first_error=0x0080 and sticky=0x0081. Pulse err_clear -> both read 0.
